// File: rtl/fifo_write_arbiter_if.sv
// Write-port bundle between two word producers, the arbiter and the FIFO write side.
// The arbiter takes the slave view; producers and the FIFO side take the master view.
interface fifo_write_arbiter_if #(
   parameter int DATA_W = 32
);
   logic [1:0]        req_i;
   logic [DATA_W-1:0] data0_i;
   logic [DATA_W-1:0] data1_i;
   logic              wrfull_i;
   logic [1:0]        grant_o;
   logic [1:0]        ack_o;
   logic              wrreq_o;
   logic [DATA_W-1:0] data_o;
   logic              busy_o;

   modport slave (
      input  req_i, data0_i, data1_i, wrfull_i,
      output grant_o, ack_o, wrreq_o, data_o, busy_o
   );

   modport master (
      output req_i, data0_i, data1_i, wrfull_i,
      input  grant_o, ack_o, wrreq_o, data_o, busy_o
   );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter for one FIFO write port: grant 1 cycle after request, one
// GAP cycle after each burst; wrfull_i stalls the owner indefinitely with the grant held.
module fifo_write_arbiter #(
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 16
) (
   input logic              clk_i,
   input logic              reset_i,
   fifo_write_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

   localparam logic [8:0] LAST_BEAT = 9'(BURST_LEN - 1);

   state_t            state_q, state_d;
   logic              sel_q, sel_d;
   logic              ptr_q, ptr_d;
   logic [8:0]        cnt_q, cnt_d;
   logic [1:0]        grant_q, grant_d;
   logic              wrreq;
   logic [DATA_W-1:0] owner_dat;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         sel_q   <= 1'b0;
         ptr_q   <= 1'b0;
         cnt_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
      end
   end

   // Only the owner's request counts; a full FIFO blocks the beat without releasing.
   assign wrreq     = (state_q == XFER) && bus.req_i[sel_q] && !bus.wrfull_i;
   assign owner_dat = sel_q ? bus.data1_i : bus.data0_i;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      case (state_q)
         IDLE: begin
            if (bus.req_i != 2'b00) begin
               sel_d   = (bus.req_i == 2'b11) ? ptr_q : bus.req_i[1];
               grant_d = sel_d ? 2'b10 : 2'b01;
               cnt_d   = '0;
               state_d = XFER;
            end
         end
         XFER: begin
            if ((wrreq && (cnt_q == LAST_BEAT)) || !bus.req_i[sel_q]) begin
               state_d = GAP;
               grant_d = 2'b00;
               ptr_d   = ~sel_q;
            end else if (wrreq) begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.grant_o = grant_q;
   assign bus.busy_o  = (state_q == XFER);
   assign bus.wrreq_o = wrreq;
   assign bus.ack_o   = wrreq ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
   assign bus.data_o  = (state_q == XFER) ? owner_dat : '0;

   a_no_write_when_full : assert property (
      @(posedge clk_i) disable iff (reset_i) !(bus.wrreq_o && bus.wrfull_i));
   a_ack_onehot_with_wrreq : assert property (
      @(posedge clk_i) disable iff (reset_i)
      $onehot0(bus.ack_o) && ((bus.ack_o == 2'b00) || bus.wrreq_o));
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: BURST_LEN=16 instance plus a BURST_LEN=1 instance.
module tb_fifo_write_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] w0 = '0;
   logic [31:0] w1 = '0;

   always #5 clk = ~clk;

   fifo_write_arbiter_if #(.DATA_W(32)) bus ();
   fifo_write_arbiter_if #(.DATA_W(32)) bus1 ();

   fifo_write_arbiter #(.DATA_W(32), .BURST_LEN(16)) dut (
      .clk_i(clk), .reset_i(rst), .bus(bus.slave));
   fifo_write_arbiter #(.DATA_W(32), .BURST_LEN(1)) dut1 (
      .clk_i(clk), .reset_i(rst), .bus(bus1.slave));

   // {grant, ack, wrreq, busy}
   wire [5:0] st  = {bus.grant_o, bus.ack_o, bus.wrreq_o, bus.busy_o};
   wire [5:0] st1 = {bus1.grant_o, bus1.ack_o, bus1.wrreq_o, bus1.busy_o};

   localparam logic [5:0] S_IDLE  = 6'b00_00_0_0;
   localparam logic [5:0] S_BEAT0 = 6'b01_01_1_1;
   localparam logic [5:0] S_BEAT1 = 6'b10_10_1_1;
   localparam logic [5:0] S_HOLD0 = 6'b01_00_0_1;
   localparam logic [5:0] S_HOLD1 = 6'b10_00_0_1;

   // Producers advance their word on ack, then new inputs go in at the falling edge.
   task automatic step(input logic [1:0] req, input logic full);
      if (bus.ack_o[0]) w0 = w0 + 32'd1;
      if (bus.ack_o[1]) w1 = w1 + 32'd1;
      @(negedge clk);
      bus.req_i    = req;
      bus.wrfull_i = full;
      bus.data0_i  = 32'hA000_0000 + w0;
      bus.data1_i  = 32'hB000_0000 + w1;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.req_i = 2'b00;  bus.wrfull_i = 1'b0;
      bus.data0_i = '0;   bus.data1_i = '0;
      bus1.req_i = 2'b00; bus1.wrfull_i = 1'b0;
      bus1.data0_i = 32'h0000_1111; bus1.data1_i = 32'h0000_2222;
      w0 = '0; w1 = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.req_i = 2'b11; bus.data0_i = 32'hDEAD_BEEF; bus.data1_i = 32'hCAFE_F00D;
      #1;
      checks++;
      if (st !== S_IDLE) begin
         errors++; $display("FAIL reset_status: got %b expected %b", st, S_IDLE);
      end
      checks++;
      if (bus.data_o !== 32'h0) begin
         errors++; $display("FAIL reset_data: got %h expected %h", bus.data_o, 32'h0);
      end
      @(negedge clk);
      #1;
      checks++;
      if (st !== S_IDLE) begin
         errors++; $display("FAIL reset_held_req: got %b expected %b", st, S_IDLE);
      end
   endtask

   task automatic test_single_burst();
      do_reset();
      step(2'b01, 1'b0);
      checks++;
      if (st !== S_IDLE) begin
         errors++; $display("FAIL single_pre_grant: got %b expected %b", st, S_IDLE);
      end
      for (int i = 0; i < 16; i++) begin
         step(2'b01, 1'b0);
         checks++;
         if (st !== S_BEAT0 || bus.data_o !== 32'hA000_0000 + w0) begin
            errors++;
            $display("FAIL single_beat%0d: got %b/%h expected %b/%h", i, st, bus.data_o,
                     S_BEAT0, 32'hA000_0000 + w0);
         end
      end
      step(2'b01, 1'b0);
      checks++;
      if (st !== S_IDLE) begin
         errors++; $display("FAIL single_gap: got %b expected %b", st, S_IDLE);
      end
      step(2'b01, 1'b0);
      checks++;
      if (st !== S_IDLE) begin
         errors++; $display("FAIL single_idle: got %b expected %b", st, S_IDLE);
      end
      step(2'b01, 1'b0);
      checks++;
      if (st !== S_BEAT0) begin
         errors++; $display("FAIL single_regrant: got %b expected %b", st, S_BEAT0);
      end
   endtask

   task automatic test_alternate();
      logic [5:0]  exp_st;
      logic [31:0] exp_dat;
      do_reset();
      step(2'b11, 1'b0);
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 16; i++) begin
            step(2'b11, 1'b0);
            exp_st  = (b == 1) ? S_BEAT1 : S_BEAT0;
            exp_dat = (b == 1) ? 32'hB000_0000 + w1 : 32'hA000_0000 + w0;
            checks++;
            if (st !== exp_st || bus.data_o !== exp_dat) begin
               errors++;
               $display("FAIL alt_burst%0d_beat%0d: got %b/%h expected %b/%h", b, i, st,
                        bus.data_o, exp_st, exp_dat);
            end
         end
         step(2'b11, 1'b0);
         checks++;
         if (st !== S_IDLE) begin
            errors++; $display("FAIL alt_gap%0d: got %b expected %b", b, st, S_IDLE);
         end
         step(2'b11, 1'b0);
         checks++;
         if (st !== S_IDLE) begin
            errors++; $display("FAIL alt_idle%0d: got %b expected %b", b, st, S_IDLE);
         end
      end
   endtask

   task automatic test_full_stall();
      do_reset();
      step(2'b01, 1'b0);
      for (int i = 0; i < 7; i++) begin
         step(2'b01, 1'b0);
         checks++;
         if (st !== S_BEAT0 || bus.data_o !== 32'hA000_0000 + w0) begin
            errors++; $display("FAIL stall_pre%0d: got %b/%h expected %b/%h", i, st,
                               bus.data_o, S_BEAT0, 32'hA000_0000 + w0);
         end
      end
      for (int i = 0; i < 5; i++) begin
         step(2'b01, 1'b1);
         checks++;
         if (st !== S_HOLD0) begin
            errors++; $display("FAIL stall_full%0d: got %b expected %b", i, st, S_HOLD0);
         end
      end
      for (int i = 0; i < 9; i++) begin
         step(2'b01, 1'b0);
         checks++;
         if (st !== S_BEAT0 || bus.data_o !== 32'hA000_0007 + i) begin
            errors++; $display("FAIL stall_post%0d: got %b/%h expected %b/%h", i, st,
                               bus.data_o, S_BEAT0, 32'hA000_0007 + i);
         end
      end
      step(2'b01, 1'b0);
      checks++;
      if (st !== S_IDLE) begin
         errors++; $display("FAIL stall_total16: got %b expected %b", st, S_IDLE);
      end
   endtask

   task automatic test_full_last();
      do_reset();
      step(2'b01, 1'b0);
      for (int i = 0; i < 15; i++) step(2'b01, 1'b0);
      step(2'b01, 1'b1);
      checks++;
      if (st !== S_HOLD0) begin
         errors++; $display("FAIL last_full_blocked: got %b expected %b", st, S_HOLD0);
      end
      step(2'b01, 1'b0);
      checks++;
      if (st !== S_BEAT0 || bus.data_o !== 32'hA000_000F) begin
         errors++; $display("FAIL last_beat16: got %b/%h expected %b/%h", st, bus.data_o,
                            S_BEAT0, 32'hA000_000F);
      end
      step(2'b01, 1'b0);
      checks++;
      if (st !== S_IDLE) begin
         errors++; $display("FAIL last_gap: got %b expected %b", st, S_IDLE);
      end
   endtask

   task automatic test_release();
      do_reset();
      step(2'b10, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(2'b11, 1'b0);
         checks++;
         if (st !== S_BEAT1 || bus.data_o !== 32'hB000_0000 + w1) begin
            errors++; $display("FAIL rel_beat%0d: got %b/%h expected %b/%h", i, st,
                               bus.data_o, S_BEAT1, 32'hB000_0000 + w1);
         end
      end
      step(2'b01, 1'b0);
      checks++;
      if (st !== S_HOLD1) begin
         errors++; $display("FAIL rel_drop: got %b expected %b", st, S_HOLD1);
      end
      step(2'b01, 1'b0);
      checks++;
      if (st !== S_IDLE) begin
         errors++; $display("FAIL rel_gap: got %b expected %b", st, S_IDLE);
      end
      step(2'b01, 1'b0);
      checks++;
      if (st !== S_IDLE) begin
         errors++; $display("FAIL rel_idle: got %b expected %b", st, S_IDLE);
      end
      step(2'b01, 1'b0);
      checks++;
      if (st !== S_BEAT0) begin
         errors++; $display("FAIL rel_grant0: got %b expected %b", st, S_BEAT0);
      end
   endtask

   // Reset lands inside requester 1's burst, while the pointer favours requester 1.
   task automatic test_reset_mid_burst();
      do_reset();
      step(2'b11, 1'b0);
      for (int i = 0; i < 18; i++) step(2'b11, 1'b0);
      for (int i = 0; i < 9; i++) step(2'b11, 1'b0);
      checks++;
      if (st !== S_BEAT1) begin
         errors++; $display("FAIL mid_beat9: got %b expected %b", st, S_BEAT1);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (st !== S_IDLE || bus.data_o !== 32'h0) begin
         errors++; $display("FAIL mid_reset_now: got %b/%h expected %b/%h", st, bus.data_o,
                            S_IDLE, 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (st !== S_IDLE) begin
         errors++; $display("FAIL mid_release: got %b expected %b", st, S_IDLE);
      end
      step(2'b11, 1'b0);
      checks++;
      if (st !== S_BEAT0) begin
         errors++; $display("FAIL mid_first_grant0: got %b expected %b", st, S_BEAT0);
      end
   endtask

   task automatic test_burst_len1();
      logic [5:0]  exp_st;
      logic [31:0] exp_dat;
      do_reset();
      @(negedge clk);
      bus1.req_i = 2'b11;
      #1;
      checks++;
      if (st1 !== S_IDLE) begin
         errors++; $display("FAIL bl1_idle: got %b expected %b", st1, S_IDLE);
      end
      for (int g = 0; g < 4; g++) begin
         @(negedge clk); #1;
         exp_st  = (g % 2 == 1) ? S_BEAT1 : S_BEAT0;
         exp_dat = (g % 2 == 1) ? 32'h0000_2222 : 32'h0000_1111;
         checks++;
         if (st1 !== exp_st || bus1.data_o !== exp_dat) begin
            errors++; $display("FAIL bl1_grant%0d: got %b/%h expected %b/%h", g, st1,
                               bus1.data_o, exp_st, exp_dat);
         end
         @(negedge clk); #1;
         checks++;
         if (st1 !== S_IDLE) begin
            errors++; $display("FAIL bl1_gap%0d: got %b expected %b", g, st1, S_IDLE);
         end
         @(negedge clk); #1;
         checks++;
         if (st1 !== S_IDLE) begin
            errors++; $display("FAIL bl1_arb%0d: got %b expected %b", g, st1, S_IDLE);
         end
      end
   endtask

   initial begin
      bus.req_i = 2'b00;  bus.wrfull_i = 1'b0;  bus.data0_i = '0;  bus.data1_i = '0;
      bus1.req_i = 2'b00; bus1.wrfull_i = 1'b0; bus1.data0_i = '0; bus1.data1_i = '0;
      test_reset();
      test_single_burst();
      test_alternate();
      test_full_stall();
      test_full_last();
      test_release();
      test_reset_mid_burst();
      test_burst_len1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
